ldm_stm_sequencer: RTL and testbench

- Multi-register transfer sequencer for LDM, STM, PUSH and POP.
- Latches the register list and base value, and computes the transfer byte count (popcount x 4).
- Drives the ALU second-operand select and bit-count value for the base/SP update, then walks the list lowest register first, issuing one memory beat per register with a req/ack handshake.
- Sits between the decoder and the datapath and is the producer of the select code and bit-count operand that the ALU src2 mux consumes.

---
 rtl/ldm_stm_sequencer_pkg.sv | 31 +++
 rtl/priority_enc_popcnt.sv | 29 ++
 rtl/ldm_stm_sequencer.sv | 168 ++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared CPU definitions for the multi-register transfer sequencer:
// ALU src2 select codes, transfer op encodings, FSM states and special register indices.
package ldm_stm_sequencer_pkg;

    localparam logic [2:0] S2_RM            = 3'd0;
    localparam logic [2:0] S2_BIT_COUNT     = 3'd4;
    localparam logic [2:0] S2_NOT_BIT_COUNT = 3'd5;

    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {
        OP_LDM  = 2'd0,
        OP_STM  = 2'd1,
        OP_PUSH = 2'd2,
        OP_POP  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_XFER = 3'd2,
        ST_WB   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic op_is_load(input op_t op);
        return (op == OP_LDM) || (op == OP_POP);
    endfunction

endpackage

// File: rtl/priority_enc_popcnt.sv
// Combinational lowest-set-bit encoder and population count over a W-bit mask.
// Also used by the decoder for count-dependent timing.
module priority_enc_popcnt #(
    parameter int W     = 9,
    parameter int IDX_W = $clog2(W),
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     i_mask,
    output logic [IDX_W-1:0] o_low_idx,
    output logic [CNT_W-1:0] o_count,
    output logic             o_any
);

    always_comb begin
        o_low_idx = '0;
        o_count   = '0;
        // Scanning from the top down leaves the lowest set bit as the final winner.
        for (int i = W - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_low_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < W; i++) begin
            o_count = o_count + CNT_W'(i_mask[i]);
        end
        o_any = |i_mask;
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM/PUSH/POP sequencer: computes the transfer size for the base/SP update,
// then issues one req/ack memory beat per listed register, lowest register first.
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int LIST_W = 9,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [LIST_W-1:0] reg_list,
    input  logic [ADDR_W-1:0] base,
    input  logic              base_in_list,
    input  logic              mem_ack,
    output logic              busy,
    output logic [2:0]        alu_src2_choose,
    output logic              alu_cin,
    output logic [ADDR_W-1:0] bit_count_number,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        reg_idx,
    output logic              rf_we,
    output logic              base_we,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam int IDX_W = $clog2(LIST_W);
    localparam int CNT_W = $clog2(LIST_W + 1);

    state_t            r_state;
    state_t            w_next_state;
    op_t               r_op;
    logic [LIST_W-1:0] r_mask;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_start_addr;
    logic [3:0]        r_beat;
    logic              r_base_in_list;

    logic [LIST_W-1:0] w_enc_in;
    logic [IDX_W-1:0]  w_low_idx;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_any;
    logic [LIST_W-1:0] w_rest;
    logic [ADDR_W-1:0] w_count_bytes;
    logic [2:0]        w_calc_sel;
    logic              w_calc_cin;
    logic              w_load;

    // One encoder serves both jobs: popcount of the incoming list while idle,
    // lowest remaining register once the list is latched.
    assign w_enc_in = (r_state == ST_IDLE) ? reg_list : r_mask;

    priority_enc_popcnt #(
        .W(LIST_W)
    ) u_enc (
        .i_mask   (w_enc_in),
        .o_low_idx(w_low_idx),
        .o_count  (w_cnt),
        .o_any    (w_any)
    );

    assign w_count_bytes = ADDR_W'({w_cnt, 2'b00});
    assign w_rest        = r_mask & ~(LIST_W'(1) << w_low_idx);
    assign w_calc_sel    = (r_op == OP_PUSH) ? S2_NOT_BIT_COUNT : S2_BIT_COUNT;
    assign w_calc_cin    = (r_op == OP_PUSH);
    assign w_load        = op_is_load(r_op);
    assign dbg_state     = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_op           <= OP_LDM;
            r_mask         <= '0;
            r_count        <= '0;
            r_start_addr   <= '0;
            r_beat         <= '0;
            r_base_in_list <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && start) begin
                r_op           <= op_t'(op);
                r_mask         <= reg_list;
                r_count        <= w_count_bytes;
                r_beat         <= '0;
                r_base_in_list <= base_in_list;
                // PUSH is full-descending: the block starts below SP.
                r_start_addr   <= (op_t'(op) == OP_PUSH) ? (base - w_count_bytes) : base;
            end
            if (r_state == ST_XFER && mem_ack) begin
                r_mask <= w_rest;
                r_beat <= r_beat + 4'd1;
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        busy             = 1'b0;
        alu_src2_choose  = S2_RM;
        alu_cin          = 1'b0;
        bit_count_number = '0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        reg_idx          = '0;
        rf_we            = 1'b0;
        base_we          = 1'b0;
        done             = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                busy             = 1'b1;
                alu_src2_choose  = w_calc_sel;
                alu_cin          = w_calc_cin;
                bit_count_number = r_count;
                w_next_state     = w_any ? ST_XFER : ST_DONE;
            end
            ST_XFER: begin
                busy             = 1'b1;
                bit_count_number = r_count;
                mem_req          = 1'b1;
                mem_we           = !w_load;
                mem_addr         = r_start_addr + ADDR_W'({r_beat, 2'b00});
                reg_idx          = 4'(w_low_idx);
                // The top list bit is LR for PUSH and PC for POP.
                if (w_low_idx == IDX_W'(LIST_W - 1)) begin
                    if (r_op == OP_PUSH) begin
                        reg_idx = REG_LR;
                    end else if (r_op == OP_POP) begin
                        reg_idx = REG_PC;
                    end
                end
                rf_we = mem_ack && w_load;
                if (mem_ack && (w_rest == '0)) begin
                    w_next_state = ST_WB;
                end
            end
            ST_WB: begin
                busy             = 1'b1;
                bit_count_number = r_count;
                alu_src2_choose  = w_calc_sel;
                alu_cin          = w_calc_cin;
                // A loaded base register must not be overwritten by the writeback.
                base_we          = !((r_op == OP_LDM) && r_base_in_list);
                w_next_state     = ST_DONE;
            end
            ST_DONE: begin
                busy             = 1'b1;
                bit_count_number = r_count;
                done             = 1'b1;
                w_next_state     = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: a vector table of complete transfers
// plus hand-written stall, start-while-busy and reset-abort sequences.
module tb_ldm_stm_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [8:0]  reg_list;
    logic [31:0] base;
    logic        base_in_list;
    logic        mem_ack;
    logic        busy;
    logic [2:0]  alu_src2_choose;
    logic        alu_cin;
    logic [31:0] bit_count_number;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  reg_idx;
    logic        rf_we;
    logic        base_we;
    logic        done;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    ldm_stm_sequencer #(.LIST_W(9), .ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .op              (op),
        .reg_list        (reg_list),
        .base            (base),
        .base_in_list    (base_in_list),
        .mem_ack         (mem_ack),
        .busy            (busy),
        .alu_src2_choose (alu_src2_choose),
        .alu_cin         (alu_cin),
        .bit_count_number(bit_count_number),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .reg_idx         (reg_idx),
        .rf_we           (rf_we),
        .base_we         (base_we),
        .done            (done),
        .dbg_state       (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0]  op;
        logic [8:0]  list;
        logic [31:0] base;
        logic        bil;
        int          nbeats;
        logic [31:0] count;
        logic [2:0]  sel;
        logic        cin;
        logic [31:0] start_addr;
        logic [35:0] regs;      // nibble k = reg_idx of beat k
        logic        base_we;
        logic        store;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " busy"},     32'(busy), 32'd0);
        chk({tag, " sel"},      32'(alu_src2_choose), 32'd0);
        chk({tag, " cin"},      32'(alu_cin), 32'd0);
        chk({tag, " bitcnt"},   bit_count_number, 32'd0);
        chk({tag, " mem_req"},  32'(mem_req), 32'd0);
        chk({tag, " mem_we"},   32'(mem_we), 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " reg_idx"},  32'(reg_idx), 32'd0);
        chk({tag, " rf_we"},    32'(rf_we), 32'd0);
        chk({tag, " base_we"},  32'(base_we), 32'd0);
        chk({tag, " done"},     32'(done), 32'd0);
    endtask

    // Drive inputs right after the falling edge, sample 1 time unit later.
    task automatic cycle_drive(input logic s, input logic ack);
        @(negedge clk);
        start   = s;
        mem_ack = ack;
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        string t;
        t = $sformatf("v%0d", id);
        @(negedge clk);
        op           = v.op;
        reg_list     = v.list;
        base         = v.base;
        base_in_list = v.bil;
        start        = 1'b1;
        mem_ack      = 1'b0;
        #1;
        chk({t, " idle busy"}, 32'(busy), 32'd0);
        cycle_drive(1'b0, 1'b0);
        chk({t, " calc busy"},   32'(busy), 32'd1);
        chk({t, " calc sel"},    32'(alu_src2_choose), 32'(v.sel));
        chk({t, " calc cin"},    32'(alu_cin), 32'(v.cin));
        chk({t, " calc bitcnt"}, bit_count_number, v.count);
        chk({t, " calc req"},    32'(mem_req), 32'd0);
        for (int k = 0; k < v.nbeats; k++) begin
            cycle_drive(1'b0, 1'b1);
            chk($sformatf("%s beat%0d req", t, k),   32'(mem_req), 32'd1);
            chk($sformatf("%s beat%0d addr", t, k),  mem_addr, v.start_addr + 32'(4 * k));
            chk($sformatf("%s beat%0d reg", t, k),   32'(reg_idx), 32'(v.regs[k*4 +: 4]));
            chk($sformatf("%s beat%0d we", t, k),    32'(mem_we), 32'(v.store));
            chk($sformatf("%s beat%0d rf_we", t, k), 32'(rf_we), 32'(!v.store));
        end
        if (v.nbeats > 0) begin
            cycle_drive(1'b0, 1'b0);
            chk({t, " wb base_we"}, 32'(base_we), 32'(v.base_we));
            chk({t, " wb sel"},     32'(alu_src2_choose), 32'(v.sel));
            chk({t, " wb cin"},     32'(alu_cin), 32'(v.cin));
            chk({t, " wb req"},     32'(mem_req), 32'd0);
        end
        cycle_drive(1'b0, 1'b0);
        chk({t, " done"},        32'(done), 32'd1);
        chk({t, " done busy"},   32'(busy), 32'd1);
        chk({t, " done bitcnt"}, bit_count_number, v.count);
        chk({t, " done req"},    32'(mem_req), 32'd0);
        chk({t, " done bwe"},    32'(base_we), 32'd0);
        cycle_drive(1'b0, 1'b0);
        chk_quiet({t, " after"});
    endtask

    initial begin
        //            op    list    base          bil nb count  sel cin start         regs            bwe st
        vecs[0] = '{2'd1, 9'h00B, 32'h0000_1000, 1'b0, 3, 32'd12, 3'd4, 1'b0, 32'h0000_1000, 36'h310,       1'b1, 1'b1};
        vecs[1] = '{2'd2, 9'h110, 32'h0000_2000, 1'b0, 2, 32'd8,  3'd5, 1'b1, 32'h0000_1FF8, 36'hE4,        1'b1, 1'b1};
        vecs[2] = '{2'd0, 9'h006, 32'h0000_3000, 1'b1, 2, 32'd8,  3'd4, 1'b0, 32'h0000_3000, 36'h21,        1'b0, 1'b0};
        vecs[3] = '{2'd1, 9'h000, 32'h0000_4000, 1'b0, 0, 32'd0,  3'd4, 1'b0, 32'h0000_4000, 36'h0,         1'b0, 1'b1};
        vecs[4] = '{2'd3, 9'h1FF, 32'hFFFF_FFF0, 1'b0, 9, 32'd36, 3'd4, 1'b0, 32'hFFFF_FFF0, 36'hF76543210, 1'b1, 1'b0};
        vecs[5] = '{2'd0, 9'h080, 32'h0000_0010, 1'b0, 1, 32'd4,  3'd4, 1'b0, 32'h0000_0010, 36'h7,         1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'd0; reg_list = '0; base = '0;
        base_in_list = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");
        chk("reset state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // POP {R0,PC} with a two-cycle stall on beat 0 and a stray start while busy.
        @(negedge clk);
        op = 2'd3; reg_list = 9'h101; base = 32'h0000_1FF8; base_in_list = 1'b0;
        start = 1'b1; mem_ack = 1'b0;
        cycle_drive(1'b0, 1'b0);
        chk("pop calc sel", 32'(alu_src2_choose), 32'd4);
        chk("pop calc bitcnt", bit_count_number, 32'd8);
        op = 2'd1; reg_list = 9'h0F0; base = 32'h0000_9000;
        for (int s = 0; s < 2; s++) begin
            cycle_drive(1'b1, 1'b0);
            chk($sformatf("pop stall%0d req", s),   32'(mem_req), 32'd1);
            chk($sformatf("pop stall%0d addr", s),  mem_addr, 32'h0000_1FF8);
            chk($sformatf("pop stall%0d reg", s),   32'(reg_idx), 32'd0);
            chk($sformatf("pop stall%0d rf_we", s), 32'(rf_we), 32'd0);
        end
        cycle_drive(1'b0, 1'b1);
        chk("pop beat0 addr", mem_addr, 32'h0000_1FF8);
        chk("pop beat0 rf_we", 32'(rf_we), 32'd1);
        cycle_drive(1'b0, 1'b1);
        chk("pop beat1 addr", mem_addr, 32'h0000_1FFC);
        chk("pop beat1 reg", 32'(reg_idx), 32'd15);
        chk("pop beat1 we", 32'(mem_we), 32'd0);
        chk("pop beat1 rf_we", 32'(rf_we), 32'd1);
        cycle_drive(1'b0, 1'b0);
        chk("pop wb base_we", 32'(base_we), 32'd1);
        cycle_drive(1'b0, 1'b0);
        chk("pop done", 32'(done), 32'd1);
        cycle_drive(1'b0, 1'b0);
        chk_quiet("pop after");

        // Reset during the second beat of a three-register STM.
        @(negedge clk);
        op = 2'd1; reg_list = 9'h007; base = 32'h0000_5000; base_in_list = 1'b0;
        start = 1'b1; mem_ack = 1'b0;
        cycle_drive(1'b0, 1'b0);
        cycle_drive(1'b0, 1'b1);
        chk("abort beat0 addr", mem_addr, 32'h0000_5000);
        cycle_drive(1'b0, 1'b1);
        chk("abort beat1 addr", mem_addr, 32'h0000_5004);
        chk("abort beat1 reg", 32'(reg_idx), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1;
        #1;
        chk_quiet("abort");
        chk("abort state", 32'(dbg_state), 32'd0);
        for (int c = 0; c < 4; c++) begin
            cycle_drive(1'b0, 1'b1);
            chk($sformatf("abort quiet%0d req", c),  32'(mem_req), 32'd0);
            chk($sformatf("abort quiet%0d done", c), 32'(done), 32'd0);
        end
        mem_ack = 1'b0;
        run_vec(vecs[0], 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
